vga_mode_ctrl: RTL and testbench

//  Key-driven display-mode scheduler for the VGA pattern datapath. Synchronises and

---
 rtl/vga_mode_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: key-driven display-mode scheduler for the VGA pattern datapath.
// Synchronises and debounces four raw active-low buttons, runs the MANUAL/AUTO/FROZEN
// mode FSM and steps the pattern index only at frame boundaries so no frame is torn.
module vga_mode_ctrl #(
    parameter int NUM_PAT     = 8,
    parameter int MODE_W      = 3,
    parameter int DEB_CYC     = 500000,
    parameter int AUTO_FRAMES = 120
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic              key_s,
    input  logic              key_d,
    input  logic              key_f,
    input  logic              key_g,
    input  logic              frame_start,
    output logic [MODE_W-1:0] pat_sel,
    output logic              pat_upd,
    output logic              auto_en,
    output logic              freeze
);

    localparam int CNT_W = 20;
    localparam int FC_W  = 8;
    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [FC_W-1:0]   AF_LAST  = FC_W'(AUTO_FRAMES - 1);
    localparam logic [MODE_W-1:0] PAT_LAST = MODE_W'(NUM_PAT - 1);

    typedef enum logic [1:0] {ST_MANUAL, ST_AUTO, ST_FROZEN} state_t;
    typedef enum logic [1:0] {PEND_NONE, PEND_NEXT, PEND_PREV} pend_t;

    // Key bit order everywhere: [0]=s (next), [1]=d (prev), [2]=f (auto), [3]=g (freeze)
    logic [3:0]            keys_raw;
    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            deb_q, deb_d;
    logic [3:0]            deb_dly_q;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            press;

    state_t            state_q, state_d;
    state_t            saved_q, saved_d;
    pend_t             pend_q, pend_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [MODE_W-1:0] pat_q, pat_d;
    logic              upd_q, upd_d;
    logic              auto_q, auto_d;
    logic              frz_q, frz_d;
    logic              adv_next, adv_prev;

    assign keys_raw = {key_g, key_f, key_d, key_s};

    // Press pulse appears the cycle after the debounced level has fallen
    assign press = deb_dly_q & ~deb_q;

    // Debounce: a level is accepted only after DEB_CYC consecutive differing samples
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Key synchroniser, debounce state and edge-detect history
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            deb_q     <= '1;
            deb_dly_q <= '1;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= keys_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
        end
    end

    // Mode FSM, pending request and frame-aligned pattern stepping
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        pend_d   = pend_q;
        fcnt_d   = fcnt_q;
        adv_next = 1'b0;
        adv_prev = 1'b0;

        // Frame boundary work uses the state before any same-cycle transition
        if (frame_start && state_q != ST_FROZEN) begin
            if (pend_q != PEND_NONE) begin
                adv_next = (pend_q == PEND_NEXT);
                adv_prev = (pend_q == PEND_PREV);
                pend_d   = PEND_NONE;
                if (state_q == ST_AUTO) fcnt_d = '0;
            end else if (state_q == ST_AUTO) begin
                if (fcnt_q == AF_LAST) begin
                    adv_next = 1'b1;
                    fcnt_d   = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end

        // A press landing on frame_start survives until the following frame_start
        if (state_q != ST_FROZEN) begin
            if (press[0] && press[1])  pend_d = PEND_NONE;
            else if (press[0])         pend_d = PEND_NEXT;
            else if (press[1])         pend_d = PEND_PREV;
        end

        case (state_q)
            ST_MANUAL: begin
                if (press[3]) begin
                    state_d = ST_FROZEN;
                    saved_d = ST_MANUAL;
                    pend_d  = PEND_NONE;
                end else if (press[2]) begin
                    state_d = ST_AUTO;
                    fcnt_d  = '0;
                end
            end
            ST_AUTO: begin
                if (press[3]) begin
                    state_d = ST_FROZEN;
                    saved_d = ST_AUTO;
                    pend_d  = PEND_NONE;
                end else if (press[2]) begin
                    state_d = ST_MANUAL;
                end
            end
            ST_FROZEN: begin
                if (press[3]) state_d = saved_q;
            end
            default: state_d = ST_MANUAL;
        endcase

        pat_d = pat_q;
        if (adv_next)      pat_d = (pat_q == PAT_LAST) ? '0 : pat_q + 1'b1;
        else if (adv_prev) pat_d = (pat_q == '0) ? PAT_LAST : pat_q - 1'b1;

        upd_d  = (pat_d != pat_q);
        auto_d = (state_d == ST_AUTO);
        frz_d  = (state_d == ST_FROZEN);
    end

    // Control state and registered outputs
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_MANUAL;
            saved_q <= ST_MANUAL;
            pend_q  <= PEND_NONE;
            fcnt_q  <= '0;
            pat_q   <= '0;
            upd_q   <= 1'b0;
            auto_q  <= 1'b0;
            frz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            pat_q   <= pat_d;
            upd_q   <= upd_d;
            auto_q  <= auto_d;
            frz_q   <= frz_d;
        end
    end

    assign pat_sel = pat_q;
    assign pat_upd = upd_q;
    assign auto_en = auto_q;
    assign freeze  = frz_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: directed key sequences, pattern updates checked by a
// scoreboard queue drained by a monitor on every pat_upd pulse.
module tb_vga_mode_ctrl;

    localparam int NUM_PAT     = 8;
    localparam int MODE_W      = 3;
    localparam int DEB_CYC     = 4;
    localparam int AUTO_FRAMES = 3;
    localparam int FRAME_LEN   = 50;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        keys;
    logic              frame_start;
    logic [MODE_W-1:0] pat_sel;
    logic              pat_upd;
    logic              auto_en;
    logic              freeze;

    int tests = 0;
    int fails = 0;
    int fcnt  = 0;
    logic [MODE_W-1:0] exp_q[$];
    logic [MODE_W-1:0] mon_exp;

    always #5 clk = ~clk;

    // Free-running frame timing
    always @(posedge clk) fcnt <= (fcnt == FRAME_LEN - 1) ? 0 : fcnt + 1;
    assign frame_start = (fcnt == FRAME_LEN - 1);

    vga_mode_ctrl #(
        .NUM_PAT    (NUM_PAT),
        .MODE_W     (MODE_W),
        .DEB_CYC    (DEB_CYC),
        .AUTO_FRAMES(AUTO_FRAMES)
    ) dut (
        .vga_clk    (clk),
        .sys_rst_n  (rst_n),
        .key_s      (keys[0]),
        .key_d      (keys[1]),
        .key_f      (keys[2]),
        .key_g      (keys[3]),
        .frame_start(frame_start),
        .pat_sel    (pat_sel),
        .pat_upd    (pat_upd),
        .auto_en    (auto_en),
        .freeze     (freeze)
    );

    // Monitor: every pat_upd pulse must match the next queued pattern
    always @(negedge clk) begin
        if (rst_n && pat_upd) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL upd_unexpected: pat_upd with pat_sel=%0d, no update expected", pat_sel);
            end else begin
                mon_exp = exp_q.pop_front();
                if (pat_sel !== mon_exp) begin
                    fails++;
                    $display("FAIL upd_value: pat_sel=%0d expected %0d", pat_sel, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns 1 time unit after the clock edge that samples frame_start
    task automatic wait_fs();
        int n = 0;
        @(negedge clk);
        while (!frame_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: got no frame_start expected one within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // Hold the masked keys low long enough to debounce, then release and settle
    task automatic press(input logic [3:0] mask);
        keys = ~mask;
        repeat (10) @(posedge clk);
        #1;
        keys = 4'hF;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        keys  = 4'hF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pat_sel", pat_sel, 0);
        check("rst_pat_upd", pat_upd, 0);
        check("rst_auto_en", auto_en, 0);
        check("rst_freeze",  freeze,  0);
        rst_n = 1'b1;

        // Short bounce must not register; a clean press steps to 1
        wait_fs();
        keys = 4'b1110;
        repeat (3) @(posedge clk);
        #1;
        keys = 4'hF;
        wait_fs();
        wait_fs();
        check("bounce_no_change", pat_sel, 0);
        exp_q.push_back(1);
        press(4'b0001);
        wait_fs();
        check("next_0_to_1", pat_sel, 1);

        // Wrap in both directions
        exp_q.push_back(0);
        press(4'b0010);
        wait_fs();
        check("prev_1_to_0", pat_sel, 0);
        exp_q.push_back(7);
        press(4'b0010);
        wait_fs();
        check("prev_wrap_0_to_7", pat_sel, 7);
        exp_q.push_back(0);
        press(4'b0001);
        wait_fs();
        check("next_wrap_7_to_0", pat_sel, 0);

        // AUTO: advance every third frame
        exp_q.push_back(1);
        exp_q.push_back(2);
        press(4'b0100);
        check("auto_on", auto_en, 1);
        wait_fs(); check("auto_f1", pat_sel, 0);
        wait_fs(); check("auto_f2", pat_sel, 0);
        wait_fs(); check("auto_f3", pat_sel, 1);
        wait_fs(); check("auto_f4", pat_sel, 1);
        wait_fs(); check("auto_f5", pat_sel, 1);
        wait_fs(); check("auto_f6", pat_sel, 2);
        press(4'b0100);
        check("auto_off", auto_en, 0);
        repeat (10) wait_fs();
        check("manual_static", pat_sel, 2);

        // Freeze out of AUTO with frame count at 1, then resume from it
        press(4'b0100);
        wait_fs();
        press(4'b1000);
        check("frz_freeze", freeze, 1);
        check("frz_auto_en", auto_en, 0);
        wait_fs();
        press(4'b0001);
        repeat (9) wait_fs();
        check("frz_static", pat_sel, 2);
        wait_fs();
        press(4'b1000);
        check("unfrz_auto_en", auto_en, 1);
        check("unfrz_freeze", freeze, 0);
        exp_q.push_back(3);
        wait_fs(); check("resume_f1", pat_sel, 2);
        wait_fs(); check("resume_f2", pat_sel, 3);

        // Simultaneous next/prev cancels out
        press(4'b0100);
        check("manual_again", auto_en, 0);
        wait_fs();
        press(4'b0011);
        wait_fs();
        wait_fs();
        check("both_cancel", pat_sel, 3);

        // Asynchronous reset mid-AUTO
        press(4'b0100);
        check("auto_before_rst", auto_en, 1);
        wait_fs();
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_pat_sel", pat_sel, 0);
        check("midrst_pat_upd", pat_upd, 0);
        check("midrst_auto_en", auto_en, 0);
        check("midrst_freeze",  freeze,  0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) wait_fs();
        check("post_rst_pat_sel", pat_sel, 0);
        check("post_rst_auto_en", auto_en, 0);
        check("post_rst_freeze",  freeze,  0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
